// File: rtl/dwt_sched_pkg.sv
// dwt_sched_pkg
// Shared types and defaults for the DWT feature scheduler.
//   state_t    : scheduler FSM state encoding (also exposed on state_dbg)
//   DEF_*      : default parameter values used by dwt_feature_scheduler
//   res_w()    : width of the extractor mean/sum results, DATA_W + log2(LENGTH)
package dwt_sched_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_FEED  = 3'd2,
      S_WAIT  = 3'd3,
      S_STORE = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   localparam int DEF_NUM_BANDS = 4;
   localparam int DEF_LENGTH    = 8;
   localparam int DEF_DATA_W    = 32;
   localparam int DEF_TIMEOUT   = 64;

   // A sum of LENGTH signed DATA_W values needs log2(LENGTH) guard bits.
   function automatic int res_w(input int data_w, input int length);
      return data_w + $clog2(length);
   endfunction

endpackage

// File: rtl/dwt_feature_scheduler.sv
// dwt_feature_scheduler
// Time-shares one dwt_extractor across all subbands of a frame. On start the
// extractor is cleared, LENGTH coefficients are streamed from each band in
// order 0..NUM_BANDS-1, and after each band the extractor results are
// captured and presented as one tagged feature beat.
//
// Optional feature: define DWT_SCHED_TIMEOUT_EN to add a WAIT-state watchdog
// (parameter TIMEOUT, sticky output timeout_err).
//
// Ports:
//   clk, rst          clock; synchronous active-low reset
//   start             frame start pulse, honoured only in IDLE
//   band_valid/data   per-band coefficient streams (data packed band-major)
//   band_ready        one-hot ready to the band currently being fed
//   ext_rst/en/coeff  clear, sample enable and coefficient to the extractor
//   ext_valid, ext_*  extractor results
//   feat_*            captured feature beat (feat_valid is a one-cycle strobe)
//   state_dbg         current FSM state
//   busy, done        activity flag; one-cycle end-of-frame pulse
//   timeout_err       sticky watchdog flag (DWT_SCHED_TIMEOUT_EN only)
//
// Handshake: a coefficient moves on a rising edge where band_valid[b] and
// band_ready[b] are both high; ready never depends on valid, and a source
// holding valid low simply stalls the band without losing its place.
module dwt_feature_scheduler
   import dwt_sched_pkg::*;
#(
   parameter int NUM_BANDS = DEF_NUM_BANDS,
   parameter int LENGTH    = DEF_LENGTH,
   parameter int DATA_W    = DEF_DATA_W
`ifdef DWT_SCHED_TIMEOUT_EN
   ,
   parameter int TIMEOUT   = DEF_TIMEOUT
`endif
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                start,
   input  logic [NUM_BANDS-1:0]                band_valid,
   input  logic [NUM_BANDS*DATA_W-1:0]         band_data,
   output logic [NUM_BANDS-1:0]                band_ready,
   output logic                                ext_rst,
   output logic                                ext_en,
   output logic [DATA_W-1:0]                   ext_coeff,
   input  logic                                ext_valid,
   input  logic [DATA_W-1:0]                   ext_max,
   input  logic [DATA_W-1:0]                   ext_min,
   input  logic [res_w(DATA_W, LENGTH)-1:0]    ext_mean,
   input  logic [res_w(DATA_W, LENGTH)-1:0]    ext_sum,
   output logic                                feat_valid,
   output logic [$clog2(NUM_BANDS)-1:0]        feat_band,
   output logic [DATA_W-1:0]                   feat_max,
   output logic [DATA_W-1:0]                   feat_min,
   output logic [res_w(DATA_W, LENGTH)-1:0]    feat_mean,
   output logic [res_w(DATA_W, LENGTH)-1:0]    feat_sum,
   output logic [2:0]                          state_dbg,
   output logic                                busy,
   output logic                                done
`ifdef DWT_SCHED_TIMEOUT_EN
   ,
   output logic                                timeout_err
`endif
);

   localparam int IW = $clog2(NUM_BANDS);
   localparam int CW = $clog2(LENGTH) + 1;

   state_t               state;
   logic [IW-1:0]        idx;
   logic [CW-1:0]        cnt;
   logic [NUM_BANDS-1:0] sel;
   logic [DATA_W-1:0]    coeff_mux;
   logic                 feed_act;
   logic                 xfer;
   logic                 last_band;

`ifdef DWT_SCHED_TIMEOUT_EN
   localparam int WW = $clog2(TIMEOUT + 1);
   logic [WW-1:0]        wcnt;
`endif

   // Band select decode and coefficient mux.
   always_comb begin
      sel       = '0;
      coeff_mux = '0;
      for (int b = 0; b < NUM_BANDS; b++) begin
         if (idx == IW'(b)) begin
            sel[b]    = 1'b1;
            coeff_mux = band_data[b*DATA_W +: DATA_W];
         end
      end
   end

   // Everything combinational is gated with rst so that a reset asserted
   // mid-frame silences the outputs before the reset edge arrives.
   assign feed_act   = rst && (state == S_FEED);
   assign xfer       = feed_act && |(band_valid & sel);
   assign last_band  = (idx == IW'(NUM_BANDS - 1));

   assign band_ready = feed_act ? sel : '0;
   assign ext_en     = xfer;
   assign ext_coeff  = feed_act ? coeff_mux : '0;
   assign ext_rst    = !rst || (state == S_CLEAR);
   assign feat_valid = rst && (state == S_STORE);
   assign done       = rst && (state == S_DONE);
   assign busy       = rst && (state != S_IDLE);
   assign state_dbg  = state;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= S_IDLE;
         idx       <= '0;
         cnt       <= '0;
         feat_band <= '0;
         feat_max  <= '0;
         feat_min  <= '0;
         feat_mean <= '0;
         feat_sum  <= '0;
`ifdef DWT_SCHED_TIMEOUT_EN
         wcnt        <= '0;
         timeout_err <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  idx   <= '0;
                  state <= S_CLEAR;
               end
            end
            S_CLEAR: begin
               cnt   <= '0;
`ifdef DWT_SCHED_TIMEOUT_EN
               wcnt  <= '0;
`endif
               state <= S_FEED;
            end
            S_FEED: begin
               // cnt stops at LENGTH; the band is left before it could wrap.
               if (xfer) begin
                  cnt <= cnt + 1'b1;
                  if (cnt == CW'(LENGTH - 1)) state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (ext_valid) begin
                  feat_band <= idx;
                  feat_max  <= ext_max;
                  feat_min  <= ext_min;
                  feat_mean <= ext_mean;
                  feat_sum  <= ext_sum;
                  state     <= S_STORE;
               end
`ifdef DWT_SCHED_TIMEOUT_EN
               // A stuck extractor costs this band its beat but not the frame.
               else if (wcnt == WW'(TIMEOUT - 1)) begin
                  timeout_err <= 1'b1;
                  if (last_band) begin
                     state <= S_DONE;
                  end else begin
                     idx   <= idx + 1'b1;
                     state <= S_CLEAR;
                  end
               end else begin
                  wcnt <= wcnt + 1'b1;
               end
`endif
            end
            S_STORE: begin
               if (last_band) begin
                  state <= S_DONE;
               end else begin
                  idx   <= idx + 1'b1;
                  state <= S_CLEAR;
               end
            end
            S_DONE: begin
               // start in this cycle is deliberately dropped.
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dwt_feature_scheduler.sv
`timescale 1ns/1ps
module tb_dwt_feature_scheduler;
   import dwt_sched_pkg::*;

   localparam int NB  = 4;
   localparam int LEN = 8;
   localparam int DW  = 32;
   localparam int RW  = DW + 3;
   localparam int IW  = 2;
   localparam int BW  = IW + DW + DW + RW;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic start = 1'b0;
   always #5 clk = ~clk;

   logic [NB-1:0]    band_valid;
   logic [NB-1:0]    band_ready;
   logic [NB*DW-1:0] band_data;
   logic             ext_rst, ext_en, ext_valid;
   logic [DW-1:0]    ext_coeff, ext_max, ext_min;
   logic [RW-1:0]    ext_mean, ext_sum;
   logic             feat_valid;
   logic [IW-1:0]    feat_band;
   logic [DW-1:0]    feat_max, feat_min;
   logic [RW-1:0]    feat_mean, feat_sum;
   logic [2:0]       state_dbg;
   logic             busy, done;
`ifdef DWT_SCHED_TIMEOUT_EN
   logic             timeout_err;
`endif

   dwt_feature_scheduler #(.NUM_BANDS(NB), .LENGTH(LEN), .DATA_W(DW)) dut (
      .clk(clk), .rst(rst), .start(start),
      .band_valid(band_valid), .band_data(band_data), .band_ready(band_ready),
      .ext_rst(ext_rst), .ext_en(ext_en), .ext_coeff(ext_coeff),
      .ext_valid(ext_valid), .ext_max(ext_max), .ext_min(ext_min),
      .ext_mean(ext_mean), .ext_sum(ext_sum),
      .feat_valid(feat_valid), .feat_band(feat_band),
      .feat_max(feat_max), .feat_min(feat_min),
      .feat_mean(feat_mean), .feat_sum(feat_sum),
      .state_dbg(state_dbg), .busy(busy), .done(done)
`ifdef DWT_SCHED_TIMEOUT_EN
      , .timeout_err(timeout_err)
`endif
   );

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- stimulus table ----------------
   typedef struct {
      logic [DW-1:0] base;
      logic [DW-1:0] step;
      logic [DW-1:0] emax;
      logic [DW-1:0] emin;
      logic [RW-1:0] esum;
   } vec_t;
   vec_t tbl[12];

   // ---------------- band sources ----------------
   int            ent[NB] = '{0, 1, 2, 3};
   logic [3:0]    src_k[NB];
   logic [NB-1:0] stall = '0;
   logic          src_clr = 1'b1;

   always_comb begin
      band_valid = '0;
      band_data  = '0;
      for (int b = 0; b < NB; b++) begin
         band_valid[b] = (src_k[b] < 4'd8) && !stall[b];
         band_data[b*DW +: DW] = tbl[ent[b]].base + tbl[ent[b]].step * DW'(src_k[b]);
      end
   end

   always @(posedge clk) begin
      for (int b = 0; b < NB; b++) begin
         if (src_clr) src_k[b] <= 4'd0;
         else if (band_valid[b] && band_ready[b]) src_k[b] <= src_k[b] + 4'd1;
      end
   end

   // ---------------- extractor model ----------------
   logic signed [DW-1:0] x_max, x_min;
   logic [RW-1:0]        x_sum;
   logic [3:0]           x_cnt;
   logic [1:0]           x_lat = 2'd0;
   logic                 x_valid = 1'b0;
   int                   x_band = 0;
   int                   block_band = -1;
   logic                 stray = 1'b0;
   int                   xfer_n = 0;

   always @(posedge clk) begin
      x_valid <= 1'b0;
      if (ext_rst) begin
         x_max  <= 32'sh8000_0000;
         x_min  <= 32'sh7FFF_FFFF;
         x_sum  <= '0;
         x_cnt  <= 4'd0;
         x_lat  <= 2'd0;
         xfer_n <= 0;
      end else if (ext_en) begin
         if ($signed(ext_coeff) > x_max) x_max <= ext_coeff;
         if ($signed(ext_coeff) < x_min) x_min <= ext_coeff;
         x_sum  <= x_sum + {{3{ext_coeff[DW-1]}}, ext_coeff};
         x_cnt  <= x_cnt + 4'd1;
         xfer_n <= xfer_n + 1;
         if (x_cnt == 4'd7) x_lat <= 2'd3;
         for (int b = 0; b < NB; b++) if (band_ready[b]) x_band <= b;
      end else if (x_lat != 2'd0) begin
         x_lat <= x_lat - 2'd1;
         if (x_lat == 2'd1 && x_band != block_band) x_valid <= 1'b1;
      end
   end

   assign ext_valid = x_valid | stray;
   assign ext_max   = x_max;
   assign ext_min   = x_min;
   assign ext_sum   = x_sum;
   assign ext_mean  = RW'($signed(x_sum) >>> 3);

   // ---------------- scoreboard ----------------
   logic [BW-1:0] exp_q[$];
   int            exp_done = 0;
   logic          prev_last = 1'b0;
   logic [BW-1:0] mon_e;
   logic [RW-1:0] mon_mean;

   always @(negedge clk) begin
      if (rst) begin
         if (feat_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", 1, 0);
            end else begin
               mon_e    = exp_q.pop_front();
               mon_mean = RW'($signed(mon_e[RW-1:0]) >>> 3);
               chk("beat_band", feat_band, mon_e[BW-1 -: IW]);
               chk("beat_max",  feat_max,  mon_e[RW+2*DW-1 -: DW]);
               chk("beat_min",  feat_min,  mon_e[RW+DW-1 -: DW]);
               chk("beat_sum",  feat_sum,  mon_e[RW-1:0]);
               chk("beat_mean", feat_mean, mon_mean);
               chk("beat_xfers", xfer_n, LEN);
            end
         end
         if (done) begin
            chk("done_after_last", prev_last, 1);
            if (exp_done == 0) chk("unexpected_done", 1, 0);
            else exp_done--;
         end
         prev_last = feat_valid && (feat_band == 2'd3);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic push_frame(input int f, input int skip_b);
      for (int b = 0; b < NB; b++) begin
         if (b != skip_b)
            exp_q.push_back({IW'(b), tbl[4*f+b].emax, tbl[4*f+b].emin, tbl[4*f+b].esum});
      end
      exp_done++;
   endtask

   task automatic run_frame(input int f, input int stall_b, input int skip_b,
                            input bit glitch, input bit timing_chk);
      bit fin = 0, g_used = 0, s_used = 0, r_used = 0;
      int s_left = 0, feed0 = 0;
      for (int b = 0; b < NB; b++) ent[b] = 4*f + b;
      stall = '0;
      @(negedge clk); src_clr = 1'b1;
      @(negedge clk); src_clr = 1'b0;
      push_frame(f, skip_b);
      start = 1'b1;
      @(negedge clk); start = 1'b0;
      if (timing_chk) begin
         chk("clear_ext_rst", ext_rst, 1);
         chk("clear_busy", busy, 1);
         chk("clear_ready", band_ready, 0);
      end
      for (int cyc = 0; cyc < 600 && !fin; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         stray = 1'b0;
         if (timing_chk && cyc == 0) chk("first_xfer", {ext_en, band_ready}, 5'b1_0001);
         if (band_ready[0]) feed0++;
         if (done) begin
            fin = 1;
            if (glitch) start = 1'b1;
         end else if (glitch && !g_used && band_ready != '0) begin
            start = 1'b1;
            g_used = 1;
         end
         if (glitch && !r_used && band_ready[0] && src_k[0] == 4'd2) begin
            stray = 1'b1;
            r_used = 1;
         end
         if (s_left > 0) begin
            chk("stall_en", ext_en, 0);
            chk("stall_ready", band_ready, 4'b0001 << stall_b);
            s_left--;
            if (s_left == 0) stall = '0;
         end else if (!s_used && stall_b >= 0 && src_k[stall_b] == 4'd4) begin
            stall[stall_b] = 1'b1;
            s_left = 5;
            s_used = 1;
         end
      end
      if (!fin) chk("frame_timeout", 0, 1);
      @(negedge clk); start = 1'b0;
      repeat (4) @(negedge clk);
      chk("idle_after", busy, 0);
      chk("state_idle", state_dbg, S_IDLE);
      chk("queue_drained", exp_q.size(), 0);
      chk("done_count", exp_done, 0);
      chk("feat_hold", feat_max, tbl[4*f+3].emax);
      if (timing_chk) chk("feed_len", feed0, LEN);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_ext_rst"}, ext_rst, 1);
      chk({tag, "_ready"}, band_ready, 0);
      chk({tag, "_ext_en"}, ext_en, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_feat_valid"}, feat_valid, 0);
      chk({tag, "_done"}, done, 0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      tbl[0]  = '{32'd0,  32'd1, 32'd7,  32'd0,  35'd28};
      tbl[1]  = '{32'd10, 32'd1, 32'd17, 32'd10, 35'd108};
      tbl[2]  = '{32'd20, 32'd1, 32'd27, 32'd20, 35'd188};
      tbl[3]  = '{32'd30, 32'd1, 32'd37, 32'd30, 35'd268};
      tbl[4]  = '{32'hFFFF_FFFC, 32'd1, 32'd3, 32'hFFFF_FFFC, 35'h7_FFFF_FFFC};
      tbl[5]  = '{32'd100, 32'hFFFF_FFFD, 32'd100, 32'd79, 35'd716};
      tbl[6]  = '{32'h7FFF_FFFF, 32'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 35'h3_FFFF_FFF8};
      tbl[7]  = '{32'h8000_0000, 32'd0, 32'h8000_0000, 32'h8000_0000, 35'h4_0000_0000};
      tbl[8]  = tbl[0];
      tbl[9]  = tbl[1];
      tbl[10] = tbl[2];
      tbl[11] = tbl[3];

      // power-on reset
      rst = 1'b0;
      @(negedge clk); @(negedge clk);
      check_reset_outputs("por");
      chk("por_state", state_dbg, S_IDLE);
      chk("por_feat_max", feat_max, 0);
      chk("por_feat_sum", feat_sum, 0);
`ifdef DWT_SCHED_TIMEOUT_EN
      chk("por_timeout_err", timeout_err, 0);
`endif
      @(negedge clk); rst = 1'b1; src_clr = 1'b0;

      // table-driven frames
      run_frame(0, -1, -1, 0, 1);
      run_frame(1, -1, -1, 0, 0);

      // reset in the middle of FEED
      for (int b = 0; b < NB; b++) ent[b] = b;
      @(negedge clk); src_clr = 1'b1;
      @(negedge clk); src_clr = 1'b0;
      start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int cyc = 0; cyc < 20 && src_k[0] != 4'd3; cyc++) @(negedge clk);
      chk("pre_reset_feed", state_dbg, S_FEED);
      rst = 1'b0;
      #1;
      check_reset_outputs("rst_comb");
      @(negedge clk);
      check_reset_outputs("rst_edge");
      chk("rst_state", state_dbg, S_IDLE);
      chk("rst_feat_max", feat_max, 0);
      chk("rst_feat_band", feat_band, 0);
      @(negedge clk); @(negedge clk);
      rst = 1'b1;
      repeat (30) @(negedge clk);
      chk("rst_quiet_busy", busy, 0);

      // stall on band 1, spurious start in FEED and DONE, stray ext_valid
      run_frame(2, 1, -1, 1, 0);

`ifdef DWT_SCHED_TIMEOUT_EN
      chk("pre_to_err", timeout_err, 0);
      block_band = 1;
      run_frame(0, -1, 1, 0, 0);
      block_band = -1;
      chk("timeout_err_set", timeout_err, 1);
      rst = 1'b0;
      @(negedge clk);
      chk("timeout_err_clr", timeout_err, 0);
      @(negedge clk); rst = 1'b1;
`endif

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not complete, expected finish");
      $fatal(1);
   end

endmodule
